softusb_rx_ng: RTL and testbench

- Parametrised next-generation USB receive front end for the softusb core, sitting between the transceiver pins and the packet engine.
- Oversamples the line and recovers bit timing with an edge-aligned phase counter.
- Performs NRZI decode, sync detection, bit destuffing and byte assembly.
- Adds packet-level checking: PID complement check, CRC5/CRC16 residual check and byte-alignment check, with a per-packet status word reported on EOP.

---
 rtl/softusb_rx_ng.sv | 238 +++++++++++++++++++++++
 tb/tb_softusb_rx_ng.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softusb_rx_ng.sv
// USB receive front end: oversampled bit recovery, NRZI decode, sync detect,
// destuffing, byte assembly and per-packet PID/CRC/alignment status.
module softusb_rx_ng #(
   parameter int OVERSAMPLE = 4,
   parameter int LS_DIV     = 8,
   parameter int SYNC_MIN   = 5,
   parameter int IDLE_BITS  = 8
) (
   input  logic       i_usb_clk,
   input  logic       i_rxreset_n,
   input  logic       i_rx,
   input  logic       i_rxp,
   input  logic       i_rxm,
   input  logic       i_low_speed,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_active,
   output logic       o_rx_error,
   output logic       o_rx_done,
   output logic [3:0] o_rx_status
);
   localparam int P_FS = OVERSAMPLE;
   localparam int P_LS = OVERSAMPLE * LS_DIV;
   localparam int PW   = $clog2(P_LS + 1);
   localparam logic [PW-1:0] LAST_FS = PW'(P_FS - 1);
   localparam logic [PW-1:0] LAST_LS = PW'(P_LS - 1);
   localparam logic [PW-1:0] HALF_FS = PW'(P_FS / 2);
   localparam logic [PW-1:0] HALF_LS = PW'(P_LS / 2);
   localparam int JW = $clog2(IDLE_BITS + 1);
   localparam logic [JW-1:0] J_LAST     = JW'(IDLE_BITS - 1);
   localparam logic [2:0]    SYNC_MIN_C = 3'(SYNC_MIN);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_ABORT} state_t;

   state_t        r_state, w_state_next;
   logic [1:0]    r_rx_s, r_rxp_s, r_rxm_s;
   logic          r_line_d, r_line_s;
   logic [PW-1:0] r_phase;
   logic [2:0]    r_zero_cnt, r_ones, r_bit_cnt;
   logic [1:0]    r_byte_cnt, r_pid_type;
   logic [7:0]    r_shift;
   logic [4:0]    r_crc5;
   logic [15:0]   r_crc16;
   logic          r_pid_err, r_stuff_err, r_se0_seen;
   logic [JW-1:0] r_j_cnt;
   logic [7:0]    r_rx_data;
   logic          r_rx_valid, r_rx_active, r_rx_error, r_rx_done;
   logic [3:0]    r_rx_status;

   logic          w_line, w_se0, w_strobe, w_bit;
   logic [PW-1:0] w_half, w_last;
   logic          w_take_bit, w_stuff_drop, w_stuff_err, w_eop, w_abort_done, w_enter_data;
   logic [7:0]    w_full_byte;
   logic [4:0]    w_crc5_next;
   logic [15:0]   w_crc16_next;
   logic          w_crc_bad, w_align_bad;

   assign w_line = r_rx_s[1] ^ i_low_speed;   // 1 = J in either speed
   assign w_se0  = ~r_rxp_s[1] & ~r_rxm_s[1];
   assign w_half = i_low_speed ? HALF_LS : HALF_FS;
   assign w_last = i_low_speed ? LAST_LS : LAST_FS;
   assign w_strobe = (r_phase == w_half);
   assign w_bit  = (w_line == r_line_s);
   assign w_full_byte  = {w_bit, r_shift[7:1]};
   assign w_crc5_next  = {r_crc5[3:0], 1'b0} ^ ((w_bit ^ r_crc5[4]) ? 5'h05 : 5'h00);
   assign w_crc16_next = {r_crc16[14:0], 1'b0} ^ ((w_bit ^ r_crc16[15]) ? 16'h8005 : 16'h0000);
   assign w_crc_bad = ((r_pid_type == 2'b01) && (r_crc5 != 5'b01100)) ||
                      ((r_pid_type == 2'b11) && (r_crc16 != 16'h800D));
   assign w_align_bad = (r_bit_cnt != 3'd0) || (r_byte_cnt == 2'd0);

   // Synchronisers and edge-aligned phase counter
   always_ff @(posedge i_usb_clk or negedge i_rxreset_n) begin
      if (!i_rxreset_n) begin
         r_rx_s   <= 2'b11;
         r_rxp_s  <= 2'b11;
         r_rxm_s  <= 2'b00;
         r_line_d <= 1'b1;
         r_phase  <= '0;
      end else begin
         r_rx_s   <= {r_rx_s[0], i_rx};
         r_rxp_s  <= {r_rxp_s[0], i_rxp};
         r_rxm_s  <= {r_rxm_s[0], i_rxm};
         r_line_d <= w_line;
         if (w_line != r_line_d)
            r_phase <= PW'(1);
         else if (r_phase >= w_last)
            r_phase <= '0;
         else
            r_phase <= r_phase + PW'(1);
      end
   end

   always_ff @(posedge i_usb_clk or negedge i_rxreset_n) begin
      if (!i_rxreset_n) r_state <= S_IDLE;
      else              r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_take_bit   = 1'b0;
      w_stuff_drop = 1'b0;
      w_stuff_err  = 1'b0;
      w_eop        = 1'b0;
      w_abort_done = 1'b0;
      w_enter_data = 1'b0;
      if (w_strobe) begin
         case (r_state)
            S_IDLE: if (!w_se0 && !w_line) w_state_next = S_SYNC;
            S_SYNC: begin
               if (w_se0) begin
                  w_state_next = S_IDLE;
               end else if (w_bit) begin
                  if (r_zero_cnt >= SYNC_MIN_C) begin
                     w_state_next = S_DATA;
                     w_enter_data = 1'b1;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (!w_se0) begin
                  if (r_se0_seen) begin
                     w_state_next = S_IDLE;
                     w_eop        = w_line;
                  end else if (r_ones == 3'd6) begin
                     w_stuff_drop = ~w_bit;
                     if (w_bit) begin
                        w_stuff_err  = 1'b1;
                        w_state_next = S_ABORT;
                     end
                  end else begin
                     w_take_bit = 1'b1;
                  end
               end
            end
            S_ABORT: begin
               if (!w_se0) begin
                  if (r_se0_seen) begin
                     w_state_next = S_IDLE;
                     w_abort_done = w_line;
                  end else if (w_line && (r_j_cnt == J_LAST)) begin
                     w_state_next = S_IDLE;
                  end
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_usb_clk or negedge i_rxreset_n) begin
      if (!i_rxreset_n) begin
         r_line_s    <= 1'b1;
         r_zero_cnt  <= '0;
         r_ones      <= '0;
         r_bit_cnt   <= '0;
         r_byte_cnt  <= '0;
         r_pid_type  <= '0;
         r_shift     <= '0;
         r_crc5      <= '0;
         r_crc16     <= '0;
         r_pid_err   <= 1'b0;
         r_stuff_err <= 1'b0;
         r_se0_seen  <= 1'b0;
         r_j_cnt     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_active <= 1'b0;
         r_rx_error  <= 1'b0;
         r_rx_done   <= 1'b0;
         r_rx_status <= '0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_rx_error  <= 1'b0;
         r_rx_done   <= 1'b0;
         r_rx_active <= (w_state_next == S_DATA);
         if (w_strobe) begin
            r_line_s <= w_line;
            if (r_state == S_DATA || r_state == S_ABORT) r_se0_seen <= w_se0;
            if (r_state == S_IDLE) r_zero_cnt <= 3'd1;
            if (r_state == S_SYNC && !w_bit && r_zero_cnt != 3'd7) r_zero_cnt <= r_zero_cnt + 3'd1;
            if (r_state == S_ABORT) r_j_cnt <= (!w_se0 && w_line) ? r_j_cnt + JW'(1) : '0;
         end
         // The sync-terminating 1 already counts toward the stuffing run
         if (w_enter_data) begin
            r_ones      <= 3'd1;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_pid_type  <= 2'b00;
            r_crc5      <= '1;
            r_crc16     <= '1;
            r_pid_err   <= 1'b0;
            r_stuff_err <= 1'b0;
            r_se0_seen  <= 1'b0;
            r_j_cnt     <= '0;
         end
         if (w_stuff_drop) r_ones <= '0;
         if (w_stuff_err) begin
            r_rx_error  <= 1'b1;
            r_stuff_err <= 1'b1;
         end
         if (w_take_bit) begin
            r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
            r_shift   <= w_full_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_byte_cnt != 2'd0) begin
               r_crc5  <= w_crc5_next;
               r_crc16 <= w_crc16_next;
            end
            if (r_bit_cnt == 3'd7) begin
               r_rx_data  <= w_full_byte;
               r_rx_valid <= 1'b1;
               if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd0) begin
                  r_pid_type <= w_full_byte[1:0];
                  r_pid_err  <= (w_full_byte[7:4] != ~w_full_byte[3:0]);
               end
            end
         end
         if (w_eop) begin
            r_rx_done   <= 1'b1;
            r_rx_status <= {w_align_bad, 1'b0, r_pid_err, w_crc_bad};
         end
         if (w_abort_done) begin
            r_rx_done   <= 1'b1;
            r_rx_status <= {1'b0, r_stuff_err, r_pid_err, 1'b0};
         end
      end
   end

   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_rx_active = r_rx_active;
   assign o_rx_error  = r_rx_error;
   assign o_rx_done   = r_rx_done;
   assign o_rx_status = r_rx_status;
endmodule

// File: tb/tb_softusb_rx_ng.sv
// Packet-level bench for softusb_rx_ng: drives NRZI line symbols, scoreboards
// received bytes and end-of-packet status words.
module tb_softusb_rx_ng;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1, rxp = 1'b1, rxm = 1'b0, low_speed = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_active, rx_error, rx_done;
   logic [3:0] rx_status;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] q_exp[$];
   logic [7:0] q_got[$];
   logic [3:0] q_stat[$];
   int   n_err_pulse = 0;
   logic err_active = 1'b0;

   int bit_per = 4;
   bit jitter_en = 1'b0;
   int jit_prev = 0;
   bit cur_j = 1'b1;
   int ones = 0;

   always #5 clk = ~clk;

   softusb_rx_ng #(.OVERSAMPLE(4), .LS_DIV(8), .SYNC_MIN(5), .IDLE_BITS(8)) u_dut (
      .i_usb_clk(clk), .i_rxreset_n(rst_n), .i_rx(rx), .i_rxp(rxp), .i_rxm(rxm),
      .i_low_speed(low_speed), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
      .o_rx_active(rx_active), .o_rx_error(rx_error), .o_rx_done(rx_done),
      .o_rx_status(rx_status)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) q_got.push_back(rx_data);
         if (rx_done) q_stat.push_back(rx_status);
         if (rx_error) begin
            n_err_pulse++;
            err_active = rx_active;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // sym: 0 = K, 1 = J, 2 = SE0; one bit period, optionally edge-jittered
   task automatic line_sym(input int sym);
      int dur;
      int jn;
      dur = bit_per;
      if (jitter_en) begin
         jn = int'($urandom_range(4)) - 2;
         dur = bit_per + jn - jit_prev;
         jit_prev = jn;
      end
      if (sym == 2) begin
         rxp = 1'b0;
         rxm = 1'b0;
      end else begin
         rx  = (sym == 1) ^ low_speed;
         rxp = rx;
         rxm = ~rx;
      end
      repeat (dur) @(negedge clk);
   endtask

   task automatic nrzi(input bit b);
      if (!b) cur_j = !cur_j;
      line_sym(cur_j ? 1 : 0);
   endtask

   task automatic send_bit(input bit b);
      nrzi(b);
      if (b) ones++;
      else ones = 0;
      if (ones == 6) begin
         nrzi(1'b0);
         ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      q_exp.push_back(v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_sync();
      cur_j = 1'b1;
      repeat (4) line_sym(1);
      repeat (7) nrzi(1'b0);
      nrzi(1'b1);
      ones = 1;
   endtask

   task automatic send_eop();
      line_sym(2);
      line_sym(2);
      cur_j = 1'b1;
      repeat (4) line_sym(1);
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (q_stat.size() > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({rx_data, rx_valid, rx_active, rx_error, rx_done, rx_status} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%02h v=%b a=%b e=%b d=%b st=%h, expected all 0",
                  rx_data, rx_valid, rx_active, rx_error, rx_done, rx_status);
      end
      $display("[TB] reset: outputs sampled");
   endtask

   // FS handshakes: ACK, then NAK followed by 0xFF to force a stuffed bit
   task automatic test_ack();
      logic [7:0] pids[2] = '{8'hD2, 8'h5A};
      bit ok;
      logic [3:0] st;
      logic [7:0] e, g;
      for (int p = 0; p < 2; p++) begin
         send_sync();
         send_byte(pids[p]);
         if (p == 1) send_byte(8'hFF);
         send_eop();
         wait_done(ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL ack_done[%0d]: no rx_done, expected one", p);
         end else begin
            st = q_stat.pop_front();
            if (st !== 4'h0) begin
               n_fail++;
               $display("FAIL ack_status[%0d]: got %h, expected 0", p, st);
            end
         end
         while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_tests++;
            if (q_got.size() == 0) begin
               n_fail++;
               $display("FAIL ack_byte[%0d]: missing, expected %02h", p, e);
            end else begin
               g = q_got.pop_front();
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL ack_byte[%0d]: got %02h, expected %02h", p, g, e);
               end
            end
         end
         n_tests++;
         if (q_got.size() != 0) begin
            n_fail++;
            $display("FAIL ack_extra[%0d]: %0d extra bytes, expected 0", p, q_got.size());
            q_got.delete();
         end
         $display("[TB] ack pkt %0d: pid %02h done", p, pids[p]);
      end
   endtask

   task automatic test_token();
      logic [7:0] last[2] = '{8'h10, 8'h11};
      logic [3:0] exp_st[2] = '{4'h0, 4'h1};
      bit ok;
      logic [3:0] st;
      logic [7:0] e, g;
      for (int p = 0; p < 2; p++) begin
         send_sync();
         send_byte(8'h69);
         send_byte(8'h00);
         send_byte(last[p]);
         send_eop();
         wait_done(ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL token_done[%0d]: no rx_done, expected one", p);
         end else begin
            st = q_stat.pop_front();
            if (st !== exp_st[p]) begin
               n_fail++;
               $display("FAIL token_status[%0d]: got %h, expected %h", p, st, exp_st[p]);
            end
         end
         while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_tests++;
            if (q_got.size() == 0) begin
               n_fail++;
               $display("FAIL token_byte[%0d]: missing, expected %02h", p, e);
            end else begin
               g = q_got.pop_front();
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL token_byte[%0d]: got %02h, expected %02h", p, g, e);
               end
            end
         end
         n_tests++;
         if (q_got.size() != 0) begin
            n_fail++;
            $display("FAIL token_extra[%0d]: %0d extra bytes, expected 0", p, q_got.size());
            q_got.delete();
         end
         $display("[TB] token pkt %0d: 69 00 %02h, expected status %h", p, last[p], exp_st[p]);
      end
   endtask

   task automatic test_data();
      logic [7:0] pid[3]    = '{8'hC3, 8'hC3, 8'hD3};
      logic [7:0] last[3]   = '{8'h00, 8'h01, 8'h00};
      logic [3:0] exp_st[3] = '{4'h0, 4'h1, 4'h2};
      bit ok;
      logic [3:0] st;
      logic [7:0] e, g;
      for (int p = 0; p < 3; p++) begin
         send_sync();
         send_byte(pid[p]);
         send_byte(8'h00);
         send_byte(last[p]);
         send_eop();
         wait_done(ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL data_done[%0d]: no rx_done, expected one", p);
         end else begin
            st = q_stat.pop_front();
            if (st !== exp_st[p]) begin
               n_fail++;
               $display("FAIL data_status[%0d]: got %h, expected %h", p, st, exp_st[p]);
            end
         end
         while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_tests++;
            if (q_got.size() == 0) begin
               n_fail++;
               $display("FAIL data_byte[%0d]: missing, expected %02h", p, e);
            end else begin
               g = q_got.pop_front();
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL data_byte[%0d]: got %02h, expected %02h", p, g, e);
               end
            end
         end
         n_tests++;
         if (q_got.size() != 0) begin
            n_fail++;
            $display("FAIL data_extra[%0d]: %0d extra bytes, expected 0", p, q_got.size());
            q_got.delete();
         end
         $display("[TB] data pkt %0d: %02h 00 %02h, expected status %h", p, pid[p], last[p], exp_st[p]);
      end
   endtask

   // Round 0 ends with EOP (abort done), round 1 idles on J (silent return)
   task automatic test_stuff_error();
      bit ok;
      int n0;
      logic [3:0] st;
      logic [7:0] g;
      for (int r = 0; r < 2; r++) begin
         n0 = n_err_pulse;
         send_sync();
         send_byte(8'hC3);
         nrzi(1'b0);
         repeat (7) nrzi(1'b1);
         if (r == 0) begin
            send_eop();
            wait_done(ok);
            n_tests++;
            if (!ok) begin
               n_fail++;
               $display("FAIL stuff_done: no rx_done, expected one");
            end else begin
               st = q_stat.pop_front();
               if (st !== 4'h4) begin
                  n_fail++;
                  $display("FAIL stuff_status: got %h, expected 4", st);
               end
            end
            n_tests++;
            if (err_active !== 1'b0) begin
               n_fail++;
               $display("FAIL stuff_active: rx_active=%b at rx_error, expected 0", err_active);
            end
         end else begin
            cur_j = 1'b1;
            repeat (12) line_sym(1);
            n_tests++;
            if (q_stat.size() != 0) begin
               n_fail++;
               $display("FAIL idle_abort_done: %0d rx_done strobes, expected 0", q_stat.size());
               q_stat.delete();
            end
         end
         n_tests++;
         if (n_err_pulse != n0 + 1) begin
            n_fail++;
            $display("FAIL stuff_error[%0d]: %0d rx_error strobes, expected 1", r, n_err_pulse - n0);
         end
         n_tests++;
         if (q_got.size() != 1) begin
            n_fail++;
            $display("FAIL stuff_bytes[%0d]: %0d bytes, expected 1", r, q_got.size());
         end else begin
            g = q_got.pop_front();
            n_tests++;
            if (g !== 8'hC3) begin
               n_fail++;
               $display("FAIL stuff_pid[%0d]: got %02h, expected c3", r, g);
            end
         end
         q_got.delete();
         q_exp.delete();
         $display("[TB] stuff error round %0d complete", r);
      end
   endtask

   task automatic test_low_speed();
      bit ok;
      logic [3:0] st;
      logic [3:0] exp_st[2] = '{4'h0, 4'h8};
      logic [7:0] e, g;
      low_speed = 1'b1;
      bit_per   = 32;
      jitter_en = 1'b1;
      jit_prev  = 0;
      cur_j     = 1'b1;
      repeat (4) line_sym(1);
      for (int p = 0; p < 2; p++) begin
         send_sync();
         send_byte(8'hD2);
         if (p == 1) begin
            send_byte(8'h00);
            send_byte(8'h00);
            repeat (3) send_bit(1'b0);
         end
         send_eop();
         wait_done(ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL ls_done[%0d]: no rx_done, expected one", p);
         end else begin
            st = q_stat.pop_front();
            if (st !== exp_st[p]) begin
               n_fail++;
               $display("FAIL ls_status[%0d]: got %h, expected %h", p, st, exp_st[p]);
            end
         end
         while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_tests++;
            if (q_got.size() == 0) begin
               n_fail++;
               $display("FAIL ls_byte[%0d]: missing, expected %02h", p, e);
            end else begin
               g = q_got.pop_front();
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL ls_byte[%0d]: got %02h, expected %02h", p, g, e);
               end
            end
         end
         n_tests++;
         if (q_got.size() != 0) begin
            n_fail++;
            $display("FAIL ls_extra[%0d]: %0d extra bytes, expected 0", p, q_got.size());
            q_got.delete();
         end
         $display("[TB] low-speed pkt %0d done, expected status %h", p, exp_st[p]);
      end
      low_speed = 1'b0;
      bit_per   = 4;
      jitter_en = 1'b0;
      jit_prev  = 0;
      cur_j     = 1'b1;
      repeat (8) line_sym(1);
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [3:0] st;
      logic [7:0] g;
      send_sync();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      #2;
      n_tests++;
      if (rx_active !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_active: rx_active=%b before reset, expected 1", rx_active);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({rx_data, rx_valid, rx_active, rx_error, rx_done, rx_status} !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got data=%02h a=%b st=%h, expected all 0",
                  rx_data, rx_active, rx_status);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cur_j = 1'b1;
      repeat (8) line_sym(1);
      n_tests++;
      if (q_stat.size() != 0 || q_got.size() != 0) begin
         n_fail++;
         $display("FAIL rst_mid_quiet: %0d done / %0d bytes after reset, expected 0/0",
                  q_stat.size(), q_got.size());
         q_stat.delete();
         q_got.delete();
      end
      q_exp.delete();
      send_sync();
      send_byte(8'hD2);
      send_eop();
      wait_done(ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rst_ack_done: no rx_done, expected one");
      end else begin
         st = q_stat.pop_front();
         if (st !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_ack_status: got %h, expected 0", st);
         end
      end
      n_tests++;
      if (q_got.size() != 1) begin
         n_fail++;
         $display("FAIL rst_ack_count: %0d bytes, expected 1", q_got.size());
      end else begin
         g = q_got.pop_front();
         n_tests++;
         if (g !== q_exp[0]) begin
            n_fail++;
            $display("FAIL rst_ack_byte: got %02h, expected %02h", g, q_exp[0]);
         end
      end
      q_got.delete();
      q_exp.delete();
      $display("[TB] reset mid-packet then ACK complete");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (8) line_sym(1);
      test_ack();
      test_token();
      test_data();
      test_stuff_error();
      test_low_speed();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
